// File: rtl/sdram_avs_bridge.sv
// Avalon-MM slave front end for the SDRAM controller: show-ahead request FIFO toward the
// access FSM, in-order read data return, and host throttling on FIFO-full / read limit.
module sdram_avs_bridge #(
  parameter int AVS_DW      = 16,
  parameter int AVS_AW      = 25,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_RD_PEND = 4,
  localparam int AVS_BYTE   = AVS_DW / 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [AVS_AW-1:0]   avs_address,
  input  logic [AVS_DW-1:0]   avs_writedata,
  input  logic [AVS_BYTE-1:0] avs_byteenable,
  output logic                avs_waitrequest,
  output logic [AVS_DW-1:0]   avs_readdata,
  output logic                avs_readdatavalid,
  output logic                bus_req_valid,
  output logic                bus_req_write,
  output logic [AVS_AW-1:0]   bus_req_address,
  output logic [AVS_DW-1:0]   bus_req_writedata,
  output logic [AVS_BYTE-1:0] bus_req_byteenable,
  input  logic                bus_req_ready,
  input  logic                bus_resp_valid,
  input  logic [AVS_DW-1:0]   bus_resp_readdata,
  output logic                err_unexp_resp
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int RPW = $clog2(MAX_RD_PEND + 1);

  typedef struct packed {
    logic                write;
    logic [AVS_AW-1:0]   address;
    logic [AVS_DW-1:0]   writedata;
    logic [AVS_BYTE-1:0] byteenable;
  } entry_t;

  entry_t         mem [FIFO_DEPTH];
  entry_t         head;
  logic [PW:0]    wr_ptr, rd_ptr;
  logic [RPW-1:0] rd_pend;
  logic           empty, full, rd_limit;
  logic           accept, rd_accept, push, pop, resp_dec;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rd_limit = (rd_pend == RPW'(MAX_RD_PEND));

  // A simultaneous read+write is a write, so the read limit never blocks it.
  assign avs_waitrequest = reset | full | (avs_read & ~avs_write & rd_limit);
  assign accept    = (avs_read | avs_write) & ~avs_waitrequest;
  assign rd_accept = accept & avs_read & ~avs_write;
  assign push      = accept;
  assign pop       = bus_req_valid & bus_req_ready;
  assign resp_dec  = bus_resp_valid & (rd_pend != '0);

  assign head               = mem[rd_ptr[PW-1:0]];
  assign bus_req_valid      = ~empty;
  assign bus_req_write      = head.write;
  assign bus_req_address    = head.address;
  assign bus_req_writedata  = head.writedata;
  assign bus_req_byteenable = head.byteenable;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= '{write: avs_write, address: avs_address,
                               writedata: avs_writedata, byteenable: avs_byteenable};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      rd_pend           <= '0;
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= '0;
      err_unexp_resp    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({rd_accept, resp_dec})
        2'b10:   rd_pend <= rd_pend + RPW'(1);
        2'b01:   rd_pend <= rd_pend - RPW'(1);
        default: rd_pend <= rd_pend;
      endcase
      avs_readdatavalid <= resp_dec;
      if (bus_resp_valid) avs_readdata <= bus_resp_readdata;
      if (bus_resp_valid && rd_pend == '0) err_unexp_resp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_avs_bridge.sv
// Directed bench for sdram_avs_bridge: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_sdram_avs_bridge;
  localparam int DW = 16, AW = 25, BW = 2, DEPTH = 4, MAXP = 4;

  logic          clk = 1'b0, reset;
  logic          avs_read, avs_write, avs_waitrequest, avs_readdatavalid;
  logic [AW-1:0] avs_address, bus_req_address;
  logic [DW-1:0] avs_writedata, avs_readdata, bus_req_writedata, bus_resp_readdata;
  logic [BW-1:0] avs_byteenable, bus_req_byteenable;
  logic          bus_req_valid, bus_req_write, bus_req_ready, bus_resp_valid, err_unexp_resp;

  sdram_avs_bridge #(.AVS_DW(DW), .AVS_AW(AW), .FIFO_DEPTH(DEPTH), .MAX_RD_PEND(MAXP)) dut (
    .clk(clk), .reset(reset),
    .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .bus_req_valid(bus_req_valid), .bus_req_write(bus_req_write),
    .bus_req_address(bus_req_address), .bus_req_writedata(bus_req_writedata),
    .bus_req_byteenable(bus_req_byteenable), .bus_req_ready(bus_req_ready),
    .bus_resp_valid(bus_resp_valid), .bus_resp_readdata(bus_resp_readdata),
    .err_unexp_resp(err_unexp_resp)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queued commands in push order, pending read count, response flags
  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
  } req_t;
  req_t          exp_q[$];
  int            m_pend = 0;
  bit            m_err = 0, m_rdv = 0, started = 0;
  logic [DW-1:0] m_rd = '0;

  function automatic bit model_wait();
    return reset || (exp_q.size() == DEPTH) || (avs_read && !avs_write && m_pend == MAXP);
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      exp_q.delete();
      m_pend = 0; m_err = 0; m_rdv = 0; m_rd = '0;
    end else begin
      bit acc, do_pop, rd_acc, rsp_ok;
      acc    = (avs_read || avs_write) && !model_wait();
      do_pop = (exp_q.size() != 0) && bus_req_ready;
      rd_acc = acc && avs_read && !avs_write;
      rsp_ok = bus_resp_valid && (m_pend > 0);
      if (do_pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back('{w: avs_write, a: avs_address, d: avs_writedata, be: avs_byteenable});
      if (bus_resp_valid && m_pend == 0) m_err = 1;
      m_pend = m_pend + (rd_acc ? 1 : 0) - (rsp_ok ? 1 : 0);
      m_rdv  = rsp_ok;
      if (bus_resp_valid) m_rd = bus_resp_readdata;
    end
  end

  // Scoreboard compare, every cycle on the inactive edge
  always @(negedge clk) begin
    if (started) begin
      chk("cmp_wait", avs_waitrequest, model_wait());
      chk("cmp_valid", bus_req_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("cmp_write", bus_req_write, exp_q[0].w);
        chk("cmp_addr", bus_req_address, exp_q[0].a);
        chk("cmp_be", bus_req_byteenable, exp_q[0].be);
        if (exp_q[0].w) chk("cmp_wdata", bus_req_writedata, exp_q[0].d);
      end
      chk("cmp_rdv", avs_readdatavalid, m_rdv);
      if (m_rdv) chk("cmp_rdata", avs_readdata, m_rd);
      chk("cmp_err", err_unexp_resp, m_err);
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_cmd(input bit r, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
    avs_read = r; avs_write = w; avs_address = a; avs_writedata = d; avs_byteenable = be;
  endtask

  task automatic send_resp(input logic [DW-1:0] d);
    bus_resp_valid = 1'b1; bus_resp_readdata = d;
    step();
    bus_resp_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_readdata = '0;
    set_cmd(0, 0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk); chk("rst_wait", avs_waitrequest, 1);
    step(); reset = 1'b0;
    @(negedge clk);
    chk("idle_wait", avs_waitrequest, 0);
    chk("idle_valid", bus_req_valid, 0);
    chk("idle_rdv", avs_readdatavalid, 0);
    chk("idle_err", err_unexp_resp, 0);

    // Single write, ready high
    step();
    bus_req_ready = 1'b1;
    set_cmd(0, 1, 25'h000100, 16'hBEEF, 2'b11);
    step(); set_cmd(0, 0, '0, '0, '0);
    @(negedge clk);
    chk("wr1_valid", bus_req_valid, 1);
    chk("wr1_write", bus_req_write, 1);
    chk("wr1_addr", bus_req_address, 25'h000100);
    chk("wr1_data", bus_req_writedata, 16'hBEEF);
    chk("wr1_be", bus_req_byteenable, 2'b11);
    step();
    @(negedge clk); chk("wr1_popped", bus_req_valid, 0);

    // Fill the FIFO with ready low, then drain in order
    step();
    bus_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(0, 1, 25'h200 + 25'(i), 16'hA000 + 16'(i), 2'b11);
      step();
    end
    set_cmd(0, 1, 25'h204, 16'hA004, 2'b01);
    @(negedge clk);
    chk("full_wait", avs_waitrequest, 1);
    step(); bus_req_ready = 1'b1;
    @(negedge clk);
    chk("full_wait_hold", avs_waitrequest, 1);
    chk("drain_head0", bus_req_address, 25'h200);
    step();
    @(negedge clk);
    chk("wait_drop", avs_waitrequest, 0);
    chk("drain_head1", bus_req_address, 25'h201);
    step(); set_cmd(0, 0, '0, '0, '0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("drain_head", bus_req_address, 25'h202 + 25'(j));
      if (j == 2) chk("drain_last_be", bus_req_byteenable, 2'b01);
      step();
    end
    @(negedge clk); chk("drain_empty", bus_req_valid, 0);

    // Read limit: 4 reads accepted, 5th stalled, a write still goes through
    step();
    for (int i = 0; i < 4; i++) begin
      set_cmd(1, 0, 25'h300 + 25'(4 * i), '0, 2'b11);
      step();
    end
    set_cmd(1, 0, 25'h310, '0, 2'b11);
    @(negedge clk); chk("rdlim_wait", avs_waitrequest, 1);
    step(); set_cmd(0, 1, 25'h400, 16'h1234, 2'b11);
    @(negedge clk); chk("wr_past_rdlim", avs_waitrequest, 0);
    step(); set_cmd(0, 0, '0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus_resp_valid = 1'b1; bus_resp_readdata = 16'h1111 * 16'(i + 1);
      end else begin
        bus_resp_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        chk("resp_rdv", avs_readdatavalid, 1);
        chk("resp_data", avs_readdata, 16'h1111 * 16'(i));
      end
      step();
    end
    @(negedge clk); chk("resp_done_rdv", avs_readdatavalid, 0);

    // Read accept coinciding with a response keeps one read pending
    step();
    set_cmd(1, 0, 25'h500, '0, 2'b11);
    step();
    set_cmd(1, 0, 25'h504, '0, 2'b11);
    send_resp(16'h5555);
    set_cmd(0, 0, '0, '0, '0);
    @(negedge clk);
    chk("coin_rdv", avs_readdatavalid, 1);
    chk("coin_data", avs_readdata, 16'h5555);
    step();
    @(negedge clk); chk("coin_rdv_once", avs_readdatavalid, 0);
    step(); send_resp(16'h6666);
    @(negedge clk);
    chk("coin_second_rdv", avs_readdatavalid, 1);
    chk("coin_second_data", avs_readdata, 16'h6666);
    chk("coin_no_err", err_unexp_resp, 0);

    // Unexpected response, then reset with three entries queued
    step(); send_resp(16'h7777);
    @(negedge clk);
    chk("unexp_rdv", avs_readdatavalid, 0);
    chk("unexp_err", err_unexp_resp, 1);
    repeat (3) step();
    @(negedge clk); chk("err_sticky", err_unexp_resp, 1);
    step();
    bus_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(0, 1, 25'h600 + 25'(i), 16'hC000 + 16'(i), 2'b11);
      step();
    end
    set_cmd(0, 0, '0, '0, '0);
    @(negedge clk); chk("preq_valid", bus_req_valid, 1);
    step(); reset = 1'b1;
    @(negedge clk); chk("midrst_wait", avs_waitrequest, 1);
    step(); reset = 1'b0;
    @(negedge clk);
    chk("midrst_empty", bus_req_valid, 0);
    chk("midrst_err", err_unexp_resp, 0);
    chk("midrst_wait_low", avs_waitrequest, 0);

    // FIFO usable again after reset
    step();
    bus_req_ready = 1'b1;
    set_cmd(0, 1, 25'h700, 16'h0707, 2'b10);
    step(); set_cmd(0, 0, '0, '0, '0);
    @(negedge clk);
    chk("post_valid", bus_req_valid, 1);
    chk("post_addr", bus_req_address, 25'h700);
    step();
    @(negedge clk); chk("post_empty", bus_req_valid, 0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
